// File: rtl/ireg_skew_pkg.sv
// Shared elaboration helpers for the input skew buffer: per-channel depth,
// total stage count and the counter width derived from it.
package ireg_pkg;

  // Number of registered stages in channel k.
  function automatic int chan_depth(input int k, input int base, input int step);
    return base + k * step;
  endfunction

  // Total stages across all channels; the most tokens that can be in flight.
  function automatic int total_depth(input int nch, input int base, input int step);
    int s;
    s = 0;
    for (int k = 0; k < nch; k++) s += chan_depth(k, base, step);
    return s;
  endfunction

  // Width that holds any value 0..total_depth inclusive.
  function automatic int cnt_width(input int nch, input int base, input int step);
    return $clog2(total_depth(nch, base, step) + 1);
  endfunction

endpackage

// File: rtl/ireg_skew_if.sv
// Bundle of the skew buffer's control, input-token and output-token signals.
// master = the side feeding tokens and watching drain; slave = the buffer.
interface ireg_skew_if
  import ireg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int BASE  = 1,
  parameter int STEP  = 1
);
  localparam int CNTW = cnt_width(NCH, BASE, STEP);

  logic                   en;
  logic                   clr;
  logic [NCH-1:0]         i_valid;
  logic [NCH*WIDTH-1:0]   i_data;
  logic [NCH-1:0]         o_valid;
  logic [NCH*WIDTH-1:0]   o_data;
  logic [CNTW-1:0]        inflight;
  logic                   busy;

  modport master (
    output en, clr, i_valid, i_data,
    input  o_valid, o_data, inflight, busy
  );

  modport slave (
    input  en, clr, i_valid, i_data,
    output o_valid, o_data, inflight, busy
  );
endinterface

// File: rtl/ireg_skew_chan.sv
// One skew channel: a DEPTH-long chain of {valid, data} stages that shifts on
// en, flushes on clr, and forces data to zero whenever valid is low.
module ireg_chan #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_data,
  output logic                    o_valid,
  output logic signed [WIDTH-1:0] o_data
);

  typedef struct packed {
    logic                    v;
    logic signed [WIDTH-1:0] d;
  } stage_t;

  stage_t [DEPTH-1:0] r_stage;
  stage_t             w_stage_in;

  // Zero-gate the incoming token so invalid lanes never carry data.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_stage_in   = '0;
    w_stage_in.v = i_valid;
    if (i_valid) w_stage_in.d = i_data;
  end

  // Shift chain: reset, then flush, then shift on enable, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: every stage is reset, not just the valids: this is a flop chain, not a RAM,
    // and clean zeros keep invalid lanes at zero data from the first cycle.
    if (!rst_n) begin
      r_stage <= '0;
    end else if (clr) begin
      r_stage <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments make each stage load its neighbour's pre-edge value.
      r_stage[0] <= w_stage_in;
      for (int j = 1; j < DEPTH; j++) r_stage[j] <= r_stage[j-1];
    end
  end

  assign o_valid = r_stage[DEPTH-1].v;
  assign o_data  = r_stage[DEPTH-1].d;

endmodule

// File: rtl/ireg_skew.sv
// Multi-channel input skew buffer for the systolic array edge. Channel k
// delays its token by BASE + k*STEP enabled cycles; a registered counter
// tracks how many valid tokens are held so the caller can detect drain.
module ireg_skew
  import ireg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int BASE  = 1,
  parameter int STEP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  ireg_skew_if.slave  bus
);

  localparam int TOTAL = total_depth(NCH, BASE, STEP);
  localparam int CNTW  = cnt_width(NCH, BASE, STEP);

  // Degenerate geometries would give zero-length chains.
  if (BASE < 1 || NCH < 1 || STEP < 0) begin : g_bad_params
    $fatal(1, "ireg_skew: need BASE >= 1, NCH >= 1, STEP >= 0 (got BASE=%0d NCH=%0d STEP=%0d)",
           BASE, NCH, STEP);
  end

  logic [NCH-1:0]       w_o_valid;
  logic [NCH*WIDTH-1:0] w_o_data;
  logic [CNTW-1:0]      w_n_in;
  logic [CNTW-1:0]      w_n_out;
  logic [CNTW-1:0]      r_inflight;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    ireg_chan #(
      .WIDTH (WIDTH),
      .DEPTH (chan_depth(k, BASE, STEP))
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.en),
      .clr     (bus.clr),
      .i_valid (bus.i_valid[k]),
      .i_data  (bus.i_data[k*WIDTH +: WIDTH]),
      .o_valid (w_o_valid[k]),
      .o_data  (w_o_data[k*WIDTH +: WIDTH])
    );
  end

  // Tokens entering and leaving on an enabled edge; NCH <= TOTAL, so both fit CNTW.
  always_comb begin
    w_n_in  = CNTW'($countones(bus.i_valid));
    w_n_out = CNTW'($countones(w_o_valid));
  end

  // In-flight count follows the same priority as the stages. The sum never
  // leaves 0..TOTAL, so modular intermediate arithmetic is exact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else if (bus.clr) begin
      r_inflight <= '0;
    end else if (bus.en) begin
      r_inflight <= r_inflight + w_n_in - w_n_out;
    end
  end

  assign bus.o_valid  = w_o_valid;
  assign bus.o_data   = w_o_data;
  assign bus.inflight = r_inflight;
  assign bus.busy     = (r_inflight != '0);

endmodule

// File: tb/tb_ireg_skew.sv
// Self-checking bench for ireg_skew: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// per-channel history model of enabled-edge tokens.
module tb_ireg_skew;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int BASE  = 1;
  localparam int STEP  = 1;
  localparam int MAXD  = BASE + (NCH - 1) * STEP;
  localparam int CNTW  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ireg_skew_if #(.WIDTH(WIDTH), .NCH(NCH), .BASE(BASE), .STEP(STEP)) bus ();

  ireg_skew #(.WIDTH(WIDTH), .NCH(NCH), .BASE(BASE), .STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: each channel remembers the tokens it was offered on every enabled
  // edge since the last reset/flush; its output is the one offered D_k edges ago.
  typedef struct {
    bit         v;
    logic [7:0] d;
  } tok_t;

  tok_t hist[NCH][$];
  bit   model_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      for (int k = 0; k < NCH; k++) hist[k].delete();
      if (!rst_n) model_ok = 1'b1;
    end else if (bus.en) begin
      for (int k = 0; k < NCH; k++) begin
        tok_t t;
        t.v = bus.i_valid[k];
        t.d = bus.i_valid[k] ? bus.i_data[k*WIDTH +: WIDTH] : 8'h00;
        hist[k].push_back(t);
        if (hist[k].size() > MAXD) void'(hist[k].pop_front());
      end
    end
  end

  function automatic void model_out(output logic [NCH-1:0] v, output logic [NCH*WIDTH-1:0] d,
                                    output int cnt);
    v = '0; d = '0; cnt = 0;
    for (int k = 0; k < NCH; k++) begin
      int dk = BASE + k * STEP;
      int n  = hist[k].size();
      if (n >= dk) begin
        v[k]               = hist[k][n-dk].v;
        d[k*WIDTH +: WIDTH] = hist[k][n-dk].d;
      end
      for (int i = (n > dk) ? n - dk : 0; i < n; i++) cnt += int'(hist[k][i].v);
    end
  endfunction

  // Every-cycle comparison against the model once a reset has been seen.
  always @(negedge clk) begin
    if (model_ok) begin
      logic [NCH-1:0]       mv;
      logic [NCH*WIDTH-1:0] md;
      int                   mc;
      model_out(mv, md, mc);
      check("model o_valid",  64'(bus.o_valid),  64'(mv));
      check("model o_data",   64'(bus.o_data),   64'(md));
      check("model inflight", 64'(bus.inflight), 64'(mc));
      check("model busy",     64'(bus.busy),     64'(mc != 0));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic c, input logic [NCH-1:0] v,
                       input logic [NCH*WIDTH-1:0] d);
    bus.en = e; bus.clr = c; bus.i_valid = v; bus.i_data = d;
  endtask

  initial begin
    // Reset held two cycles under random inputs.
    rst_n = 1'b0;
    drive(1'($urandom), 1'($urandom), 4'($urandom), $urandom);
    tick();
    drive(1'($urandom), 1'($urandom), 4'($urandom), $urandom);
    tick();
    check("reset o_valid",  64'(bus.o_valid), 64'd0);
    check("reset o_data",   64'(bus.o_data), 64'd0);
    check("reset inflight", 64'(bus.inflight), 64'd0);
    check("reset busy",     64'(bus.busy), 64'd0);
    rst_n = 1'b1;

    // Skew: four tokens 10..13 launched together emerge one channel per edge.
    drive(1'b1, 1'b0, 4'b1111, {8'sd13, 8'sd12, 8'sd11, 8'sd10});
    for (int i = 1; i <= 5; i++) begin
      tick();
      drive(1'b1, 1'b0, 4'b0000, 32'h0);
      check("skew o_valid",  64'(bus.o_valid),  (i <= 4) ? 64'(1 << (i - 1)) : 64'd0);
      check("skew inflight", 64'(bus.inflight), 64'(5 - i));
      if (i <= 4) check("skew o_data", 64'(bus.o_data[(i-1)*WIDTH +: WIDTH]), 64'(9 + i));
    end

    // Stall: -5 on channel 3, two shifts, three stalled edges, two more shifts.
    drive(1'b1, 1'b0, 4'b1000, {8'hFB, 24'h0});
    tick(); drive(1'b1, 1'b0, 4'b0000, 32'h0);
    tick(); drive(1'b0, 1'b0, 4'b1111, 32'h7F7F7F7F);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall inflight", 64'(bus.inflight), 64'd1);
      check("stall o_valid",  64'(bus.o_valid), 64'd0);
    end
    drive(1'b1, 1'b0, 4'b0000, 32'h0);
    tick();
    check("stall early o_valid", 64'(bus.o_valid), 64'd0);
    tick();
    check("stall o_valid3", 64'(bus.o_valid), 64'b1000);
    check("stall o_data3",  64'(bus.o_data[3*WIDTH +: WIDTH]), 64'hFB);
    tick();
    check("stall drained", 64'(bus.busy), 64'd0);

    // Zero-gate: lane 2 offers 0x7F with valid low.
    drive(1'b1, 1'b0, 4'b1011, 32'h7F7F7F7F);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("gate o_valid2", 64'(bus.o_valid[2]), 64'd0);
      check("gate o_data2",  64'(bus.o_data[2*WIDTH +: WIDTH]), 64'd0);
    end
    drive(1'b1, 1'b0, 4'b0000, 32'h0);
    repeat (MAXD) tick();

    // Flush: fill to 10 tokens, then clr with en and full input.
    drive(1'b1, 1'b0, 4'b1111, $urandom);
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1'b1, 1'b0, 4'b1111, $urandom);
    end
    check("fill inflight", 64'(bus.inflight), 64'd10);
    drive(1'b1, 1'b1, 4'b1111, $urandom);
    tick();
    check("flush o_valid",  64'(bus.o_valid), 64'd0);
    check("flush o_data",   64'(bus.o_data), 64'd0);
    check("flush inflight", 64'(bus.inflight), 64'd0);
    check("flush busy",     64'(bus.busy), 64'd0);

    // Steady state: continuous full input saturates at 10, then a mid-stream reset.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b0, 4'b1111, $urandom);
      tick();
      if (i >= 4) check("steady inflight", 64'(bus.inflight), 64'd10);
    end
    rst_n = 1'b0;
    tick();
    check("midreset o_valid",  64'(bus.o_valid), 64'd0);
    check("midreset o_data",   64'(bus.o_data), 64'd0);
    check("midreset inflight", 64'(bus.inflight), 64'd0);
    rst_n = 1'b1;

    // Randomized traffic with occasional stalls, flushes and resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 24) == 0), 4'($urandom), $urandom);
      rst_n = ($urandom_range(0, 60) != 0);
      tick();
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'b0000, 32'h0);
    repeat (MAXD + 1) tick();
    check("final drained", 64'(bus.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
